uart_fifo_ctrl: RTL and testbench
=================================

# uart_fifo_ctrl

Buffered serial-port controller between the device controller (comEnable/comReadEnable/comDataSave/comDataLoad bus) and the 9600-baud async_receiver/async_transmitter pair. It replaces the unbuffered path: received bytes queue in an RX FIFO and CPU-written bytes queue in a TX FIFO drained by a transmit state machine. A status register, a control register and a level interrupt feed `int_i` of the CPU.

## Interface
- `DEPTH_LOG2`, default 4: each FIFO holds 2^DEPTH_LOG2 = 16 bytes.
- `clk25`  in  1  25 MHz system clock.
- `rst`  in  1  reset. Synchronous, active-high; clock clk25.
- `enable_i`  in  1  bus access strobe. Asserted for exactly one cycle per access.
- `readEnable_i`  in  1  1 = read, 0 = write. Valid with enable_i.
- `mode_i`  in  1  register select (addr[2]). 0 = DATA, 1 = STATUS/CTRL.
- `dataSave_i`  in  32  write data.
- `dataLoad_o`  out  32  read data. Combinational from mode_i and state.
- `int_o`  out  1  registered level interrupt.
- `rxdReady_i`  in  1  one-cycle pulse: receiver byte valid.
- `rxdData_i`  in  8  received byte.
- `txdBusy_i`  in  1  transmitter busy.
- `txdStart_o`  out  1  one-cycle transmit start pulse.
- `txdData_o`  out  8  byte to transmit. Held from the start pulse until the next start.

## Operation
- **DATA read** (enable_i & readEnable_i & !mode_i)
  - dataLoad_o = {24'h0, RX head}.
  - Pops RX if it is not empty.
  - If RX is empty, returns 0 and does not pop.
- **DATA write** pushes dataSave_i[7:0] into TX.
  - If TX is full, the byte is dropped and sticky txOvf is set.
- **STATUS read** (mode_i = 1)
  - Layout: bit0 = TX not full; bit1 = RX not empty; bit2 = rxOvf; bit3 = txOvf; bit4 = rxIE; bit5 = txIE; [15:8] = RX count; [23:16] = TX count; others 0.
  - Counts are 0..16, 5 significant bits.
  - The read clears rxOvf and txOvf at the end of the cycle; the returned value shows the pre-clear values.
- **CTRL write** (mode_i = 1, write): rxIE <= dataSave_i[0]; txIE <= dataSave_i[1]. Other bits are ignored.
- **RX push**: on rxdReady_i, push rxdData_i.
  - If RX is full and no pop occurs in the same cycle, the byte is dropped and rxOvf is set.
- **Simultaneous RX push and pop**
  - When full: both happen, count stays 16, no overflow.
  - When empty: read returns 0, no pop, push succeeds.
- **FIFOs**: circular buffers with DEPTH_LOG2-bit read/write pointers that wrap modulo 16, plus a (DEPTH_LOG2+1)-bit count.
- **TX FSM** (states IDLE, START, WAIT_BUSY, WAIT_DONE)
  - IDLE: if TX is not empty and !txdBusy_i, pop the head into txdData_o and go to START.
  - START: txdStart_o = 1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for txdBusy_i = 1, then go to WAIT_DONE. If busy is not seen within 4 cycles, go back to IDLE (timeout guard).
  - WAIT_DONE: wait for txdBusy_i = 0, then go to IDLE.
- **Interrupt**: int_o <= (rxIE & RX not empty) | (txIE & TX empty & FSM in IDLE).

## Timing
- Reset values:
  - All outputs: txdStart_o = 0, txdData_o = 8'h00, int_o = 0. dataLoad_o follows the reset state (STATUS read = 32'h00000001).
  - Internal state: FSM = IDLE; FIFOs empty, pointers 0; rxOvf = txOvf = rxIE = txIE = 0.
- Reset mid-operation clears both FIFOs, aborts the FSM and drops txdStart_o the next cycle. A byte already handed to the transmitter is not recalled.
- RX: rxdReady_i in cycle N makes the byte readable and bit1 = 1 from cycle N+1.
- TX: write in cycle N with an idle transmitter gives FSM to START at the N+1 edge, so txdStart_o is high during cycle N+2.
  - Back-to-back bytes are separated by the full txdBusy_i high period plus 2 cycles.
- int_o lags its condition by 1 cycle.
- All state updates occur on the posedge of clk25. There is no combinational path from bus inputs to txdStart_o or int_o.

## Test plan
- Reset: hold rst 2 cycles, then release.
  - Required: txdStart_o = 0, int_o = 0, STATUS read = 32'h00000001, DATA read = 0 with no state change.
- RX ordering: pulse rxdReady_i with 0x41, 0x42, 0x43.
  - Required: STATUS[15:8] = 3.
  - Required: three DATA reads return 0x41, 0x42, 0x43; a fourth returns 0; STATUS bit1 = 0.
- RX overflow: push 17 bytes 0x00..0x10 with no reads.
  - Required: count = 16 and bit2 = 1; the next STATUS read shows bit2 = 0.
  - Required: 16 DATA reads return 0x00..0x0F (0x10 dropped).
  - Also push a byte in the same cycle as a read at full: count stays 16 and no overflow is flagged.
- TX drain: with a transmitter model whose busy goes high 1 cycle after start for 20 cycles, write 0x55 then 0xAA.
  - Required: txdStart_o pulses with 0x55, then with 0xAA after busy falls; TX count returns to 0.
  - Write 17 bytes with busy stuck high: STATUS bit0 = 0, bit3 = 1.
- Interrupt: CTRL write 0x1, then push 0x7E.
  - Required: int_o rises 2 cycles after rxdReady_i and falls 2 cycles after the DATA read.
  - CTRL write 0x2 with TX idle and empty: int_o = 1.
- Reset mid-transmit: assert rst during WAIT_DONE with 3 bytes queued.
  - Required: no further txdStart_o pulses; TX count = 0 after reset.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_fifo_ctrl: RX/TX byte FIFOs, status/ctrl registers and TX sequencer  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_fifo_ctrl #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic        mode_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        int_o,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o
);
    localparam int                DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;

    logic [7:0]            rx_mem_q [DEPTH];
    logic [7:0]            tx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic                  rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    logic                  rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic                  int_q, int_d;
    tx_state_t             state_q, state_d;
    logic [1:0]            tmo_q, tmo_d;
    logic [7:0]            txd_data_q, txd_data_d;

    logic w_data_rd, w_data_wr, w_stat_rd, w_ctrl_wr;
    logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic w_rx_push, w_rx_pop, w_rx_drop, w_tx_push, w_tx_pop, w_tx_drop;
    logic [31:0] w_status;

    assign w_data_rd  = enable_i &  readEnable_i & ~mode_i;
    assign w_data_wr  = enable_i & ~readEnable_i & ~mode_i;
    assign w_stat_rd  = enable_i &  readEnable_i &  mode_i;
    assign w_ctrl_wr  = enable_i & ~readEnable_i &  mode_i;

    assign w_rx_empty = (rx_cnt_q == '0);
    assign w_rx_full  = (rx_cnt_q == C_FULL);
    assign w_tx_empty = (tx_cnt_q == '0);
    assign w_tx_full  = (tx_cnt_q == C_FULL);

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_rx_pop   = w_data_rd & ~w_rx_empty;
    assign w_rx_push  = rxdReady_i & (~w_rx_full | w_rx_pop);
    assign w_rx_drop  = rxdReady_i & w_rx_full & ~w_rx_pop;
    assign w_tx_push  = w_data_wr & ~w_tx_full;
    assign w_tx_drop  = w_data_wr & w_tx_full;

    always_comb begin
        w_status                        = '0;
        w_status[0]                     = ~w_tx_full;
        w_status[1]                     = ~w_rx_empty;
        w_status[2]                     = rx_ovf_q;
        w_status[3]                     = tx_ovf_q;
        w_status[4]                     = rx_ie_q;
        w_status[5]                     = tx_ie_q;
        w_status[8 +: DEPTH_LOG2+1]     = rx_cnt_q;
        w_status[16 +: DEPTH_LOG2+1]    = tx_cnt_q;
    end

    assign dataLoad_o = mode_i ? w_status
                               : {24'h0, (w_rx_empty ? 8'h00 : rx_mem_q[rx_rd_q])};

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        txd_data_d = txd_data_q;
        w_tx_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_tx_empty && !txdBusy_i) begin
                    w_tx_pop   = 1'b1;
                    txd_data_d = tx_mem_q[tx_rd_q];
                    state_d    = S_START;
                end
            end
            S_START: begin
                tmo_d   = 2'd0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Give up after four cycles so a dead transmitter cannot wedge the queue.
                if (txdBusy_i)           state_d = S_WAIT_DONE;
                else if (tmo_q == 2'd3)  state_d = S_IDLE;
                else                     tmo_d   = tmo_q + 2'd1;
            end
            S_WAIT_DONE: begin
                if (!txdBusy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_wr_d  = rx_wr_q + {{(DEPTH_LOG2-1){1'b0}}, w_rx_push};
        rx_rd_d  = rx_rd_q + {{(DEPTH_LOG2-1){1'b0}}, w_rx_pop};
        tx_wr_d  = tx_wr_q + {{(DEPTH_LOG2-1){1'b0}}, w_tx_push};
        tx_rd_d  = tx_rd_q + {{(DEPTH_LOG2-1){1'b0}}, w_tx_pop};
        rx_cnt_d = rx_cnt_q + {{DEPTH_LOG2{1'b0}}, w_rx_push} - {{DEPTH_LOG2{1'b0}}, w_rx_pop};
        tx_cnt_d = tx_cnt_q + {{DEPTH_LOG2{1'b0}}, w_tx_push} - {{DEPTH_LOG2{1'b0}}, w_tx_pop};
        // A fresh overflow wins over the clear from a coincident status read.
        rx_ovf_d = w_rx_drop | (rx_ovf_q & ~w_stat_rd);
        tx_ovf_d = w_tx_drop | (tx_ovf_q & ~w_stat_rd);
        rx_ie_d  = w_ctrl_wr ? dataSave_i[0] : rx_ie_q;
        tx_ie_d  = w_ctrl_wr ? dataSave_i[1] : tx_ie_q;
        int_d    = (rx_ie_q & ~w_rx_empty) | (tx_ie_q & w_tx_empty & (state_q == S_IDLE));
    end

    always_ff @(posedge clk25) begin
        if (w_rx_push) rx_mem_q[rx_wr_q] <= rxdData_i;
        if (w_tx_push) tx_mem_q[tx_wr_q] <= dataSave_i[7:0];
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            rx_ovf_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
            int_q      <= 1'b0;
            state_q    <= S_IDLE;
            tmo_q      <= 2'd0;
            txd_data_q <= 8'h00;
        end else begin
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ie_q    <= rx_ie_d;
            tx_ie_q    <= tx_ie_d;
            int_q      <= int_d;
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            txd_data_q <= txd_data_d;
        end
    end

    assign txdStart_o = (state_q == S_START);
    assign txdData_o  = txd_data_q;
    assign int_o      = int_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_fifo_ctrl: directed bench for the buffered UART controller        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_fifo_ctrl;
    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, readEnable = 1'b0, mode = 1'b0;
    logic [31:0] dataSave = '0;
    logic [31:0] dataLoad;
    logic        intr;
    logic        rxdReady = 1'b0;
    logic [7:0]  rxdData = '0;
    logic        txdBusy = 1'b0;
    logic        txdStart;
    logic [7:0]  txdData;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic stuck = 1'b0;
    int   busy_cnt = 0;
    logic [7:0] st_data[$];
    int         st_cyc[$];

    uart_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
        .clk25       (clk25),
        .rst         (rst),
        .enable_i    (enable),
        .readEnable_i(readEnable),
        .mode_i      (mode),
        .dataSave_i  (dataSave),
        .dataLoad_o  (dataLoad),
        .int_o       (intr),
        .rxdReady_i  (rxdReady),
        .rxdData_i   (rxdData),
        .txdBusy_i   (txdBusy),
        .txdStart_o  (txdStart),
        .txdData_o   (txdData)
    );

    always #20 clk25 = ~clk25;
    always @(posedge clk25) cyc <= cyc + 1;

    // Transmitter model: busy rises the cycle after start and stays high 20 cycles.
    always @(posedge clk25) begin
        if (stuck) begin
            txdBusy <= 1'b1;
        end else if (txdStart) begin
            busy_cnt <= 20;
            txdBusy  <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            txdBusy  <= 1'b0;
        end
    end

    always @(negedge clk25) begin
        if (txdStart) begin
            st_data.push_back(txdData);
            st_cyc.push_back(cyc);
        end
    end

    task automatic bus_rd(input logic m, output logic [31:0] d);
        @(negedge clk25);
        enable = 1'b1; readEnable = 1'b1; mode = m;
        #1 d = dataLoad;
        @(posedge clk25); #1;
        enable = 1'b0; readEnable = 1'b0; mode = 1'b0;
    endtask

    task automatic bus_wr(input logic m, input logic [31:0] v, output int wc);
        @(negedge clk25);
        enable = 1'b1; readEnable = 1'b0; mode = m; dataSave = v; wc = cyc;
        @(posedge clk25); #1;
        enable = 1'b0; mode = 1'b0; dataSave = '0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clk25);
        rxdReady = 1'b1; rxdData = b;
        @(posedge clk25); #1;
        rxdReady = 1'b0;
    endtask

    task automatic rd_push(input logic [7:0] b, output logic [31:0] d);
        @(negedge clk25);
        enable = 1'b1; readEnable = 1'b1; mode = 1'b0; rxdReady = 1'b1; rxdData = b;
        #1 d = dataLoad;
        @(posedge clk25); #1;
        enable = 1'b0; readEnable = 1'b0; rxdReady = 1'b0;
    endtask

    task automatic wait_starts(input int n, output logic ok);
        int k = 0;
        while (st_data.size() < n && k < 300) begin
            @(negedge clk25);
            k++;
        end
        ok = (st_data.size() >= n);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk25);
        #1 rst = 1'b0;
        @(negedge clk25);
        n_tests++; if (txdStart !== 1'b0) begin n_fail++; $display("FAIL reset_txdStart got=%b exp=0", txdStart); end
        n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_int got=%b exp=0", intr); end
        n_tests++; if (txdData !== 8'h00) begin n_fail++; $display("FAIL reset_txdData got=%h exp=00", txdData); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL reset_status got=%h exp=00000001", d); end
        bus_rd(1'b0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=00000000", d); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL reset_status_after_rd got=%h exp=00000001", d); end
    endtask

    task automatic test_rx_order;
        logic [31:0] d;
        logic [7:0]  exp_b [3] = '{8'h41, 8'h42, 8'h43};
        foreach (exp_b[i]) rx_push(exp_b[i]);
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000303) begin n_fail++; $display("FAIL rx_order_status got=%h exp=00000303", d); end
        foreach (exp_b[i]) begin
            bus_rd(1'b0, d);
            n_tests++; if (d !== {24'h0, exp_b[i]}) begin n_fail++; $display("FAIL rx_order_data%0d got=%h exp=%h", i, d, exp_b[i]); end
        end
        bus_rd(1'b0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_order_empty_data got=%h exp=00000000", d); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL rx_order_status_end got=%h exp=00000001", d); end
    endtask

    task automatic test_rx_overflow;
        logic [31:0] d;
        for (int i = 0; i <= 16; i++) rx_push(8'(i));
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00001007) begin n_fail++; $display("FAIL rx_ovf_status got=%h exp=00001007", d); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00001003) begin n_fail++; $display("FAIL rx_ovf_cleared got=%h exp=00001003", d); end
        for (int i = 0; i < 16; i++) begin
            bus_rd(1'b0, d);
            n_tests++; if (d !== 32'(i)) begin n_fail++; $display("FAIL rx_ovf_data%0d got=%h exp=%h", i, d, i); end
        end
        rd_push(8'h5A, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_rdpush_data got=%h exp=00000000", d); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000103) begin n_fail++; $display("FAIL rx_empty_rdpush_status got=%h exp=00000103", d); end
        bus_rd(1'b0, d);
        n_tests++; if (d !== 32'h5A) begin n_fail++; $display("FAIL rx_empty_rdpush_byte got=%h exp=0000005a", d); end
        for (int i = 0; i < 16; i++) rx_push(8'(8'h20 + i));
        rd_push(8'h30, d);
        n_tests++; if (d !== 32'h20) begin n_fail++; $display("FAIL rx_full_rdpush_data got=%h exp=00000020", d); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00001003) begin n_fail++; $display("FAIL rx_full_rdpush_status got=%h exp=00001003", d); end
        for (int i = 0; i < 16; i++) begin
            bus_rd(1'b0, d);
            n_tests++; if (d !== 32'(8'h21 + i)) begin n_fail++; $display("FAIL rx_full_drain%0d got=%h exp=%h", i, d, 8'h21 + i); end
        end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL rx_ovf_status_end got=%h exp=00000001", d); end
    endtask

    task automatic test_interrupt;
        logic [31:0] d;
        int wc;
        bus_wr(1'b1, 32'h1, wc);
        rx_push(8'h7E);
        @(negedge clk25);
        n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL int_rx_early got=%b exp=0", intr); end
        @(negedge clk25);
        n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL int_rx_rise got=%b exp=1", intr); end
        bus_rd(1'b0, d);
        n_tests++; if (d !== 32'h7E) begin n_fail++; $display("FAIL int_rx_data got=%h exp=0000007e", d); end
        @(negedge clk25);
        n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL int_rx_hold got=%b exp=1", intr); end
        @(negedge clk25);
        n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL int_rx_fall got=%b exp=0", intr); end
        bus_wr(1'b1, 32'h2, wc);
        repeat (2) @(negedge clk25);
        n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL int_tx_empty got=%b exp=1", intr); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000021) begin n_fail++; $display("FAIL int_ctrl_status got=%h exp=00000021", d); end
        bus_wr(1'b1, 32'h0, wc);
        repeat (2) @(negedge clk25);
        n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL int_disabled got=%b exp=0", intr); end
    endtask

    task automatic test_tx_drain;
        logic [31:0] d;
        logic ok;
        int wc0, wc1, n0;
        n0 = st_data.size();
        bus_wr(1'b0, 32'h55, wc0);
        bus_wr(1'b0, 32'hAA, wc1);
        wait_starts(n0 + 2, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL tx_drain_timeout got=%0d starts exp=%0d", st_data.size() - n0, 2); end
        if (ok) begin
            n_tests++; if (st_data[n0] !== 8'h55) begin n_fail++; $display("FAIL tx_first_byte got=%h exp=55", st_data[n0]); end
            n_tests++; if (st_cyc[n0] !== wc0 + 2) begin n_fail++; $display("FAIL tx_first_latency got=%0d exp=%0d", st_cyc[n0], wc0 + 2); end
            n_tests++; if (st_data[n0+1] !== 8'hAA) begin n_fail++; $display("FAIL tx_second_byte got=%h exp=aa", st_data[n0+1]); end
            n_tests++; if (st_cyc[n0+1] !== st_cyc[n0] + 23) begin n_fail++; $display("FAIL tx_gap got=%0d exp=%0d", st_cyc[n0+1], st_cyc[n0] + 23); end
        end
        repeat (30) @(negedge clk25);
        n_tests++; if (txdData !== 8'hAA) begin n_fail++; $display("FAIL tx_data_held got=%h exp=aa", txdData); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL tx_drained_status got=%h exp=00000001", d); end

        stuck = 1'b1;
        repeat (2) @(negedge clk25);
        n0 = st_data.size();
        for (int i = 0; i < 17; i++) bus_wr(1'b0, 32'(8'h60 + i), wc0);
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00100008) begin n_fail++; $display("FAIL tx_ovf_status got=%h exp=00100008", d); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00100000) begin n_fail++; $display("FAIL tx_ovf_cleared got=%h exp=00100000", d); end
        n_tests++; if (st_data.size() !== n0) begin n_fail++; $display("FAIL tx_stuck_starts got=%0d exp=%0d", st_data.size(), n0); end
        @(negedge clk25);
        rst = 1'b1; stuck = 1'b0;
        repeat (2) @(posedge clk25);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid_tx;
        logic [31:0] d;
        logic ok;
        int wc, n0;
        repeat (3) @(negedge clk25);
        n0 = st_data.size();
        for (int i = 0; i < 4; i++) bus_wr(1'b0, 32'(8'h11 + i), wc);
        wait_starts(n0 + 1, ok);
        n_tests++; if (!ok || st_data[n0] !== 8'h11) begin n_fail++; $display("FAIL mid_first_start got=%0d starts exp=1 byte 11", st_data.size() - n0); end
        repeat (5) @(negedge clk25);
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00030001) begin n_fail++; $display("FAIL mid_queued_status got=%h exp=00030001", d); end
        @(negedge clk25);
        rst = 1'b1;
        repeat (2) @(posedge clk25);
        #1 rst = 1'b0;
        n0 = st_data.size();
        repeat (80) @(negedge clk25);
        n_tests++; if (st_data.size() !== n0) begin n_fail++; $display("FAIL mid_extra_starts got=%0d exp=%0d", st_data.size(), n0); end
        bus_rd(1'b1, d);
        n_tests++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL mid_status_after_rst got=%h exp=00000001", d); end
        n_tests++; if (txdStart !== 1'b0) begin n_fail++; $display("FAIL mid_txdStart got=%b exp=0", txdStart); end
    endtask

    initial begin
        test_reset();
        test_rx_order();
        test_rx_overflow();
        test_interrupt();
        test_tx_drain();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
